abus_stage: RTL and testbench

//  Parametrised, registered A-bus source selector with a 2-entry output buffer.

---
 rtl/abus_stage.sv | 119 +++++++++++
 tb/tb_abus_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/abus_stage.sv
// Registered A-bus source selector feeding a 2-entry output buffer.
// Each accepted request samples one source and queues {value, select tag} for the ALU A operand.
module abus_stage #(
    parameter int WIDTH = 19,
    parameter int N_SRC = 14,
    parameter int SEL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [N_SRC*WIDTH-1:0] src_flat,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   sel_err,
    input  logic                   err_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_SRC);

    state_t           state_reg;
    logic [WIDTH-1:0] head_data_reg;
    logic [SEL_W-1:0] head_sel_reg;
    logic [WIDTH-1:0] tail_data_reg;
    logic [SEL_W-1:0] tail_sel_reg;
    logic             sel_err_reg;

    logic             push;
    logic             pop;
    logic             sel_bad;
    logic [WIDTH-1:0] push_data;

    // Lookup table covering every select code; code 0 and out-of-range codes read as zero.
    logic [WIDTH-1:0] src_tab [2**SEL_W];

    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_src
            if (gi >= 1 && gi <= N_SRC) begin : g_live
                assign src_tab[gi] = src_flat[(gi-1)*WIDTH +: WIDTH];
            end else begin : g_zero
                assign src_tab[gi] = '0;
            end
        end
    endgenerate

    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = head_data_reg;
    assign out_sel   = head_sel_reg;
    assign sel_err   = sel_err_reg;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign sel_bad   = (in_sel > MAX_SEL);
    assign push_data = src_tab[in_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            head_data_reg <= '0;
            head_sel_reg  <= '0;
            tail_data_reg <= '0;
            tail_sel_reg  <= '0;
            sel_err_reg   <= 1'b0;
        end else begin
            // Setting the sticky error takes priority over a simultaneous clear.
            if (push && sel_bad) begin
                sel_err_reg <= 1'b1;
            end else if (err_clr) begin
                sel_err_reg <= 1'b0;
            end

            if (flush) begin
                state_reg <= EMPTY;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (push) begin
                            head_data_reg <= push_data;
                            head_sel_reg  <= in_sel;
                            state_reg     <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head_data_reg <= push_data;
                            head_sel_reg  <= in_sel;
                        end else if (push) begin
                            tail_data_reg <= push_data;
                            tail_sel_reg  <= in_sel;
                            state_reg     <= FULL;
                        end else if (pop) begin
                            state_reg <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            head_data_reg <= tail_data_reg;
                            head_sel_reg  <= tail_sel_reg;
                            state_reg     <= ONE;
                        end
                    end
                    default: state_reg <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_abus_stage.sv
// Scoreboard bench for abus_stage: expected entries queue on accepted requests and are
// compared when the consumer takes the head.
module tb_abus_stage;

    localparam int WIDTH = 19;
    localparam int N_SRC = 14;
    localparam int SEL_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       in_sel;
    logic [N_SRC*WIDTH-1:0] src_flat;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   sel_err;
    logic                   err_clr;

    logic [WIDTH-1:0]         srcs [N_SRC];
    logic [WIDTH+SEL_W-1:0]   sb [$];
    logic                     err_m;
    int                       total = 0;
    int                       bad   = 0;

    abus_stage #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .src_flat  (src_flat),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        src_flat = '0;
        for (int i = 0; i < N_SRC; i++) src_flat[i*WIDTH +: WIDTH] = srcs[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_val(input logic [SEL_W-1:0] s);
        if (s == 0 || int'(s) > N_SRC) return '0;
        return srcs[int'(s) - 1];
    endfunction

    // Reference model, evaluated between edges for the coming rising edge.
    always @(negedge clk) begin
        logic accept;
        logic [WIDTH+SEL_W-1:0] e;
        if (!rst_n) begin
            sb.delete();
            err_m = 1'b0;
            chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
        end else begin
            chk("ovalid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            chk("iready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
            chk("sel_err", {31'd0, sel_err}, {31'd0, err_m});
            accept = in_valid && (sb.size() < 2);
            if (accept && int'(in_sel) > N_SRC) err_m = 1'b1;
            else if (err_clr) err_m = 1'b0;
            if (flush) begin
                sb.delete();
            end else begin
                if (out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[WIDTH+SEL_W-1:SEL_W]));
                    chk("out_sel", 32'(out_sel), 32'(e[SEL_W-1:0]));
                end
                if (accept) sb.push_back({exp_val(in_sel), in_sel});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold one request until accepted, bounded.
    task automatic req(input logic [SEL_W-1:0] s);
        bit done = 0;
        in_valid = 1'b1;
        in_sel   = s;
        for (int n = 0; n < 20 && !done; n++) begin
            done = in_ready;
            step();
        end
        if (!done) chk("req_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; flush = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < N_SRC; i++) srcs[i] = WIDTH'(32'h100 * (i + 1) + 7);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #11 rst_n = 1'b1;
        step();

        // 1: single transfer, one-cycle latency
        srcs[2] = 19'h1234;
        out_ready = 1'b1;
        req(4'd3);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", 32'(out_data), 32'h1234);
        step();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);

        // 2: fill, stall a third request, then drain in order
        out_ready = 1'b0;
        srcs[0] = 19'h00AA; srcs[13] = 19'h7FFFF;
        req(4'd1);
        req(4'd14);
        chk("t2_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_sel = 4'd5;
        step(); step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step();
        chk("t2_ready_back", {31'd0, in_ready}, 32'd1);

        // 3: source change after sampling does not affect the queued entry
        out_ready = 1'b0;
        srcs[1] = 19'h0011;
        req(4'd2);
        srcs[1] = 19'h0022;
        step(); step();
        chk("t3_held", 32'(out_data), 32'h0011);
        out_ready = 1'b1;
        step();

        // 4: invalid select, sticky error, set beats clear
        req(4'd15);
        chk("t4_err", {31'd0, sel_err}, 32'd1);
        step(); step();
        err_clr = 1'b1;
        req(4'd15);
        chk("t4_set_wins", {31'd0, sel_err}, 32'd1);
        step();
        chk("t4_cleared", {31'd0, sel_err}, 32'd0);
        err_clr = 1'b0;

        // 5: flush from FULL overrides push and pop
        out_ready = 1'b0;
        req(4'd4);
        req(4'd6);
        flush = 1'b1; in_valid = 1'b1; in_sel = 4'd7; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flushed", {31'd0, out_valid}, 32'd0);
        step();

        // 6: streaming push&pop, async reset mid-stream
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = SEL_W'(i % N_SRC + 1);
            srcs[i] = WIDTH'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        #1 chk("t6_async_rst", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_sel = SEL_W'(i + 8);
            srcs[i + 7] = WIDTH'($urandom);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
